// File: rtl/jt1942_dwnld_pkg.sv
// Shared types and constants for the ioctl download router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jt1942_dwnld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Active-low byte-lane masks for the 16-bit SDRAM word
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    localparam logic [21:0] PROM_START_DEF = 22'h1D000;

    // One pending SDRAM write request
    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } req_t;

    localparam req_t REQ_RST = '{addr: 22'd0, data: 8'd0, mask: MASK_NONE};

    // Lane select: odd byte lands in the high lane
    function automatic logic [1:0] lane_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jt1942_dwnld_skid.sv
// Two-slot SDRAM request buffer: one active slot driving the bus, one skid slot behind it.
// Latency: a push into an empty buffer is visible on act_o the next cycle.
// Backpressure: push with both slots held and no pop is dropped and flagged on ovf_o.
module jt1942_dwnld_skid
    import jt1942_dwnld_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  req_t push_dat_i,
    input  logic pop_i,
    output req_t act_o,
    output logic full_o,
    output logic empty_o,
    output logic ovf_o
);

    logic act_v_q, act_v_d;
    logic skd_v_q, skd_v_d;
    req_t act_q, act_d;
    req_t skd_q, skd_d;
    logic ovf_d;

    // Retire/advance on pop first, then place the incoming request in the first free slot
    always_comb begin
        act_v_d = act_v_q;
        skd_v_d = skd_v_q;
        act_d   = act_q;
        skd_d   = skd_q;
        ovf_d   = 1'b0;
        if (pop_i && act_v_q) begin
            if (skd_v_q) begin
                act_d   = skd_q;
                skd_v_d = 1'b0;
            end else begin
                act_v_d = 1'b0;
            end
        end
        if (push_i) begin
            if (!act_v_d) begin
                act_d   = push_dat_i;
                act_v_d = 1'b1;
            end else if (!skd_v_d) begin
                skd_d   = push_dat_i;
                skd_v_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Slot registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            act_v_q <= 1'b0;
            skd_v_q <= 1'b0;
            act_q   <= REQ_RST;
            skd_q   <= REQ_RST;
        end else begin
            act_v_q <= act_v_d;
            skd_v_q <= skd_v_d;
            act_q   <= act_d;
            skd_q   <= skd_d;
        end
    end

    assign act_o   = act_q;
    assign full_o  = act_v_q && skd_v_q;
    assign empty_o = !act_v_q;
    assign ovf_o   = ovf_d;

endmodule

// File: rtl/jt1942_dwnld.sv
// Routes the ioctl byte stream to the SDRAM loader or to one of PROM_N on-chip PROMs.
// Latency: PROM strobe and first SDRAM request appear 1 cycle after the ioctl byte.
// Backpressure: SDRAM requests held until prog_rdy_i; 1 skid entry, further bytes dropped with err.
module jt1942_dwnld
    import jt1942_dwnld_pkg::*;
#(
    parameter int          PROM_N     = 10,
    parameter int          PROM_AW    = 8,
    parameter logic [21:0] PROM_START = PROM_START_DEF,
    parameter int          HEADER     = 0,
    parameter bit          SWAB       = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               downloading_i,
    input  logic               ioctl_wr_i,
    input  logic [21:0]        ioctl_addr_i,
    input  logic [7:0]         ioctl_data_i,
    output logic [21:0]        prog_addr_o,
    output logic [7:0]         prog_data_o,
    output logic [1:0]         prog_mask_o,
    output logic               prog_we_o,
    input  logic               prog_rdy_i,
    output logic [PROM_N-1:0]  prom_we_o,
    output logic [PROM_AW-1:0] prom_addr_o,
    output logic [3:0]         prom_data_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [21:0] HDR_C = 22'(HEADER);
    localparam logic [21:0] PN_C  = 22'(PROM_N);

    state_t              st_q;
    logic                dl_q, done_q, err_q, gap_q;
    logic [PROM_N-1:0]   prom_we_q, prom_we_d;
    logic [PROM_AW-1:0]  prom_addr_q;
    logic [3:0]          prom_data_q;
    logic [21:0]         a, p, idx;
    logic                accept, is_sdram, push, prom_hit, prom_bad;
    logic                dl_rise, pop, drain_empty, prog_we;
    req_t                req_in, act;
    logic                full, empty, ovf;

    // Address decode of the incoming byte
    always_comb begin
        a         = ioctl_addr_i - HDR_C;
        p         = a - PROM_START;
        idx       = p >> PROM_AW;
        accept    = (st_q == ST_LOAD) && ioctl_wr_i && (ioctl_addr_i >= HDR_C);
        is_sdram  = a < PROM_START;
        push      = accept && is_sdram;
        prom_hit  = accept && !is_sdram && (idx < PN_C);
        prom_bad  = accept && !is_sdram && !(idx < PN_C);
        req_in    = '{addr: {1'b0, a[21:1]}, data: ioctl_data_i, mask: lane_mask(a[0] ^ SWAB)};
        prom_we_d = '0;
        for (int i = 0; i < PROM_N; i++) begin
            prom_we_d[i] = prom_hit && (idx == 22'(i));
        end
    end

    jt1942_dwnld_skid u_skid (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (push),
        .push_dat_i (req_in),
        .pop_i      (pop),
        .act_o      (act),
        .full_o     (full),
        .empty_o    (empty),
        .ovf_o      (ovf)
    );

    // A request is on the bus while the active slot is held, except the cycle right after a retire
    assign prog_we     = !empty && !gap_q;
    assign pop         = prog_we && prog_rdy_i;
    assign dl_rise     = downloading_i && !dl_q;
    // No pushes happen in DRAIN, so the buffer empties exactly when the last slot retires
    assign drain_empty = empty || (pop && !full);

    // Download state machine with done pulse and sticky error
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q   <= ST_IDLE;
            dl_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dl_q   <= downloading_i;
            done_q <= 1'b0;
            case (st_q)
                ST_IDLE: begin
                    if (dl_rise) begin
                        st_q  <= ST_LOAD;
                        err_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (prom_bad || ovf) err_q <= 1'b1;
                    if (!downloading_i) st_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (dl_rise) begin
                        st_q  <= ST_LOAD;
                        err_q <= 1'b0;
                    end else if (drain_empty) begin
                        st_q   <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    // PROM write strobe/data and the one-cycle gap after each SDRAM retire
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prom_we_q   <= '0;
            prom_addr_q <= '0;
            prom_data_q <= 4'd0;
            gap_q       <= 1'b0;
        end else begin
            prom_we_q <= prom_we_d;
            gap_q     <= pop;
            if (prom_hit) begin
                prom_addr_q <= p[PROM_AW-1:0];
                prom_data_q <= ioctl_data_i[3:0];
            end
        end
    end

    assign prog_we_o   = prog_we;
    assign prog_addr_o = act.addr;
    assign prog_data_o = act.data;
    assign prog_mask_o = act.mask;
    assign prom_we_o   = prom_we_q;
    assign prom_addr_o = prom_addr_q;
    assign prom_data_o = prom_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_jt1942_dwnld.sv
// Directed bench for jt1942_dwnld: per-cycle vector table on the default instance,
// plus short sequences on SWAB=1 and HEADER=16 instances.
module tb_jt1942_dwnld;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, dl = 1'b0, wr = 1'b0, rdy = 1'b0;
    logic [21:0] addr = 22'd0;
    logic [7:0]  data = 8'd0;

    logic [21:0] pa, s_pa, h_pa;
    logic [7:0]  pd, s_pd, h_pd;
    logic [1:0]  pm, s_pm, h_pm;
    logic        we, s_we, h_we;
    logic [9:0]  rwe, s_rwe, h_rwe;
    logic [7:0]  ra, s_ra, h_ra;
    logic [3:0]  rd, s_rd, h_rd;
    logic        dn, s_dn, h_dn;
    logic        er, s_er, h_er;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jt1942_dwnld u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .downloading_i(dl), .ioctl_wr_i(wr),
        .ioctl_addr_i(addr), .ioctl_data_i(data), .prog_addr_o(pa), .prog_data_o(pd),
        .prog_mask_o(pm), .prog_we_o(we), .prog_rdy_i(rdy), .prom_we_o(rwe),
        .prom_addr_o(ra), .prom_data_o(rd), .done_o(dn), .err_o(er)
    );

    jt1942_dwnld #(.SWAB(1'b1)) u_swab (
        .clk_i(clk), .rst_n_i(rst_n), .downloading_i(dl), .ioctl_wr_i(wr),
        .ioctl_addr_i(addr), .ioctl_data_i(data), .prog_addr_o(s_pa), .prog_data_o(s_pd),
        .prog_mask_o(s_pm), .prog_we_o(s_we), .prog_rdy_i(rdy), .prom_we_o(s_rwe),
        .prom_addr_o(s_ra), .prom_data_o(s_rd), .done_o(s_dn), .err_o(s_er)
    );

    jt1942_dwnld #(.HEADER(16)) u_hdr (
        .clk_i(clk), .rst_n_i(rst_n), .downloading_i(dl), .ioctl_wr_i(wr),
        .ioctl_addr_i(addr), .ioctl_data_i(data), .prog_addr_o(h_pa), .prog_data_o(h_pd),
        .prog_mask_o(h_pm), .prog_we_o(h_we), .prog_rdy_i(rdy), .prom_we_o(h_rwe),
        .prom_addr_o(h_ra), .prom_data_o(h_rd), .done_o(h_dn), .err_o(h_er)
    );

    // ctl = {rst_n, downloading, ioctl_wr, prog_rdy}; flg = {prog_we, done, err}
    typedef struct {
        logic [3:0]  ctl;
        logic [21:0] a;
        logic [7:0]  d;
        logic [2:0]  flg;
        logic [21:0] pa;
        logic [7:0]  pd;
        logic [1:0]  pm;
        logic [9:0]  rwe;
        logic [7:0]  ra;
        logic [3:0]  rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] ctl, input logic [21:0] a, input logic [7:0] d,
                               input logic [2:0] flg, input logic [21:0] xpa, input logic [7:0] xpd,
                               input logic [1:0] xpm, input logic [9:0] xrwe, input logic [7:0] xra,
                               input logic [3:0] xrd);
        vec_t r;
        r.ctl = ctl; r.a = a; r.d = d; r.flg = flg; r.pa = xpa; r.pd = xpd;
        r.pm = xpm; r.rwe = xrwe; r.ra = xra; r.rd = xrd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic [3:0] ctl, input logic [21:0] a, input logic [7:0] d);
        {rst_n, dl, wr, rdy} = ctl;
        addr = a;
        data = d;
    endtask

    // Inputs applied at negedge, sampled at posedge, outputs checked at the next negedge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) tbl.push_back(v(4'b0000, 22'h0, 8'h00, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        // two SDRAM bytes into one word
        tbl.push_back(v(4'b1110, 22'h0,     8'h12, 3'b100, 22'h0, 8'h12, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h0, 8'h12, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1110, 22'h1,     8'h34, 3'b100, 22'h0, 8'h34, 2'b01, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h0, 8'h34, 2'b01, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h0, 8'h34, 2'b01, 10'h000, 8'h00, 4'h0));
        // PROM hit, then out-of-range PROM
        tbl.push_back(v(4'b1110, 22'h1D305, 8'hA7, 3'b000, 22'h0, 8'h34, 2'b01, 10'h008, 8'h05, 4'h7));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h1DA00, 8'h55, 3'b001, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b001, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        // end with empty buffer, restart clears err
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b001, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b011, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h0, 8'h34, 2'b01, 10'h000, 8'h05, 4'h7));
        // backpressure: active + skid held, third byte overflows
        tbl.push_back(v(4'b1110, 22'h4,     8'hAA, 3'b100, 22'h2, 8'hAA, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h5,     8'hBB, 3'b100, 22'h2, 8'hAA, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h6,     8'hCC, 3'b101, 22'h2, 8'hAA, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b001, 22'h2, 8'hBB, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b101, 22'h2, 8'hBB, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b001, 22'h2, 8'hBB, 2'b01, 10'h000, 8'h05, 4'h7));
        // drain with two pending requests
        tbl.push_back(v(4'b1110, 22'h8,     8'h11, 3'b101, 22'h4, 8'h11, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1010, 22'h9,     8'h22, 3'b101, 22'h4, 8'h11, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1001, 22'h0,     8'h00, 3'b001, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b101, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1001, 22'h0,     8'h00, 3'b011, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b001, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        // re-raise during DRAIN: no done, err cleared
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h1DA00, 8'h55, 3'b001, 22'h4, 8'h22, 2'b01, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h10,    8'h5A, 3'b101, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b101, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b100, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b000, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b010, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        // reset mid-download: abandoned, no done
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h8, 8'h5A, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b1110, 22'h20,    8'h77, 3'b100, 22'h10, 8'h77, 2'b10, 10'h000, 8'h05, 4'h7));
        tbl.push_back(v(4'b0110, 22'h22,    8'h99, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1000, 22'h0,     8'h00, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b000, 22'h0, 8'h00, 2'b11, 10'h000, 8'h00, 4'h0));
        // prog_rdy with a new byte while skid full: no overflow
        tbl.push_back(v(4'b1110, 22'h40,    8'hD1, 3'b100, 22'h20, 8'hD1, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1110, 22'h41,    8'hD2, 3'b100, 22'h20, 8'hD1, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1111, 22'h42,    8'hD3, 3'b000, 22'h20, 8'hD2, 2'b01, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b100, 22'h20, 8'hD2, 2'b01, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h21, 8'hD3, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1100, 22'h0,     8'h00, 3'b100, 22'h21, 8'hD3, 2'b10, 10'h000, 8'h00, 4'h0));
        tbl.push_back(v(4'b1101, 22'h0,     8'h00, 3'b000, 22'h21, 8'hD3, 2'b10, 10'h000, 8'h00, 4'h0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drv(tbl[i].ctl, tbl[i].a, tbl[i].d);
            cyc();
            chk($sformatf("row%0d", i),
                64'({we, pa, pd, pm, rwe, ra, rd, dn, er}),
                64'({tbl[i].flg[2], tbl[i].pa, tbl[i].pd, tbl[i].pm, tbl[i].rwe, tbl[i].ra,
                     tbl[i].rd, tbl[i].flg[1], tbl[i].flg[0]}));
        end

        // SWAB=1: lane masks reversed
        drv(4'b0000, 22'h0, 8'h00); cyc(); cyc();
        drv(4'b1100, 22'h0, 8'h00); cyc();
        drv(4'b1110, 22'h0, 8'h12); cyc();
        chk("swab_even", 64'({s_we, s_pa, s_pd, s_pm, s_er}), 64'({1'b1, 22'h0, 8'h12, 2'b01, 1'b0}));
        drv(4'b1101, 22'h0, 8'h00); cyc();
        chk("swab_retire", 64'(s_we), 64'd0);
        drv(4'b1110, 22'h1, 8'h34); cyc();
        chk("swab_odd", 64'({s_we, s_pa, s_pd, s_pm, s_er}), 64'({1'b1, 22'h0, 8'h34, 2'b10, 1'b0}));
        drv(4'b1101, 22'h0, 8'h00); cyc();

        // HEADER=16: first 16 bytes discarded
        drv(4'b0000, 22'h0, 8'h00); cyc(); cyc();
        drv(4'b1100, 22'h0, 8'h00); cyc();
        for (int k = 0; k < 16; k++) begin
            drv(4'b1110, 22'(k), 8'(8'hE0 + k)); cyc();
            chk($sformatf("hdr_skip%0d", k), 64'({h_we, h_rwe, h_er}), 64'd0);
        end
        drv(4'b1110, 22'd16, 8'h9C); cyc();
        chk("hdr_first", 64'({h_we, h_pa, h_pd, h_pm, h_rwe, h_dn}),
            64'({1'b1, 22'h0, 8'h9C, 2'b10, 10'h000, 1'b0}));
        drv(4'b1100, 22'h0, 8'h00); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
